// File: rtl/alu_seq_if.sv
// Operation set shared with the sequencer, and the ALU request/response bundle.
// The shared data bus word (tri-state) is a plain port of alu_seq, not part of this bundle.
package control;
   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOT = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_ROL = 4'd8,
      OP_ROR = 4'd9,
      OP_MUL = 4'd10,
      OP_DIV = 4'd11
   } alu_op_e;
endpackage

interface alu_seq_if #(
   parameter int WIDTH = 8
);
   import control::*;

   logic             start;
   alu_op_e          op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             output_enable;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic             flag_zero;
   logic             flag_carry;
   logic             flag_remainder;
   logic             flag_div_zero;

   modport master (
      output start, op, operand_a, operand_b, output_enable,
      input  busy, done, result_hi, flag_zero, flag_carry, flag_remainder, flag_div_zero
   );

   modport slave (
      input  start, op, operand_a, operand_b, output_enable,
      output busy, done, result_hi, flag_zero, flag_carry, flag_remainder, flag_div_zero
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU. Single-cycle ops finish on the capture edge; MUL
// (shift-add) and DIV (restoring) iterate WIDTH edges. WIDTH must be >= 2.
module alu_seq
   import control::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   alu_seq_if.slave         bus,
   output wire [WIDTH-1:0]  result
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_ITER = 2'd1,
      DIV_ITER = 2'd2
   } state_e;

   state_e           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] m_r;        // multiplicand (MUL) or divisor (DIV)
   logic [WIDTH-1:0] hi_r;       // partial product high / partial remainder
   logic [WIDTH-1:0] lo_r;       // multiplier bits / dividend-quotient bits
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] result_hi_r;
   logic             zero_r;
   logic             carry_r;
   logic             rem_r;
   logic             div_zero_r;

   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH-1:0] sc_lo_s;
   logic             sc_carry_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH-1:0] mul_hi_s;
   logic [WIDTH-1:0] mul_lo_s;
   logic [WIDTH:0]   div_trial_s;
   logic [WIDTH:0]   div_diff_s;
   logic [WIDTH-1:0] div_hi_s;
   logic [WIDTH-1:0] div_lo_s;

   assign a_s   = bus.operand_a;
   assign b_s   = bus.operand_b;
   assign sum_s = {1'b0, a_s} + {1'b0, b_s};

   // Single-cycle result and carry for the op presented with start
   always_comb begin
      sc_lo_s    = ALL_ZERO;
      sc_carry_s = 1'b0;
      case (bus.op)
         OP_ADD: begin
            sc_lo_s    = sum_s[WIDTH-1:0];
            sc_carry_s = sum_s[WIDTH];
         end
         OP_SUB: begin
            sc_lo_s    = a_s - b_s;
            sc_carry_s = (a_s < b_s);
         end
         OP_AND: sc_lo_s = a_s & b_s;
         OP_OR:  sc_lo_s = a_s | b_s;
         OP_XOR: sc_lo_s = a_s ^ b_s;
         OP_NOT: sc_lo_s = ~a_s;
         OP_SHL: begin
            sc_lo_s    = {a_s[WIDTH-2:0], 1'b0};
            sc_carry_s = a_s[WIDTH-1];
         end
         OP_SHR: begin
            sc_lo_s    = {1'b0, a_s[WIDTH-1:1]};
            sc_carry_s = a_s[0];
         end
         OP_ROL: begin
            sc_lo_s    = {a_s[WIDTH-2:0], a_s[WIDTH-1]};
            sc_carry_s = a_s[WIDTH-1];
         end
         OP_ROR: begin
            sc_lo_s    = {a_s[0], a_s[WIDTH-1:1]};
            sc_carry_s = a_s[0];
         end
         // MUL/DIV run iteratively; unlisted codes complete with result 0
         default: begin
            sc_lo_s    = ALL_ZERO;
            sc_carry_s = 1'b0;
         end
      endcase
   end

   // One shift-add multiply step and one restoring-divide step
   always_comb begin
      mul_sum_s   = {1'b0, hi_r} + ({1'b0, m_r} & {(WIDTH + 1){lo_r[0]}});
      mul_hi_s    = mul_sum_s[WIDTH:1];
      mul_lo_s    = {mul_sum_s[0], lo_r[WIDTH-1:1]};
      div_trial_s = {hi_r, lo_r[WIDTH-1]};
      div_diff_s  = div_trial_s - {1'b0, m_r};
      if (div_trial_s >= {1'b0, m_r}) begin
         div_hi_s = div_diff_s[WIDTH-1:0];
         div_lo_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
         div_hi_s = div_trial_s[WIDTH-1:0];
         div_lo_s = {lo_r[WIDTH-2:0], 1'b0};
      end
   end

   // Sequencer: operand capture, iteration and registered result/flag update
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= IDLE;
         cnt_r       <= CNT_ZERO;
         m_r         <= ALL_ZERO;
         hi_r        <= ALL_ZERO;
         lo_r        <= ALL_ZERO;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         result_r    <= ALL_ZERO;
         result_hi_r <= ALL_ZERO;
         zero_r      <= 1'b0;
         carry_r     <= 1'b0;
         rem_r       <= 1'b0;
         div_zero_r  <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  if (bus.op == OP_MUL) begin
                     m_r     <= a_s;
                     lo_r    <= b_s;
                     hi_r    <= ALL_ZERO;
                     cnt_r   <= CNT_LOAD;
                     busy_r  <= 1'b1;
                     state_r <= MUL_ITER;
                  end else if ((bus.op == OP_DIV) && (b_s == ALL_ZERO)) begin
                     result_r    <= ALL_ONES;
                     result_hi_r <= a_s;
                     zero_r      <= 1'b0;
                     carry_r     <= 1'b0;
                     rem_r       <= 1'b0;
                     div_zero_r  <= 1'b1;
                     done_r      <= 1'b1;
                  end else if (bus.op == OP_DIV) begin
                     m_r     <= b_s;
                     lo_r    <= a_s;
                     hi_r    <= ALL_ZERO;
                     cnt_r   <= CNT_LOAD;
                     busy_r  <= 1'b1;
                     state_r <= DIV_ITER;
                  end else begin
                     result_r    <= sc_lo_s;
                     result_hi_r <= ALL_ZERO;
                     zero_r      <= (sc_lo_s == ALL_ZERO);
                     carry_r     <= sc_carry_s;
                     rem_r       <= 1'b0;
                     div_zero_r  <= 1'b0;
                     done_r      <= 1'b1;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            MUL_ITER: begin
               hi_r  <= mul_hi_s;
               lo_r  <= mul_lo_s;
               cnt_r <= cnt_r - CNT_LAST;
               if (cnt_r == CNT_LAST) begin
                  result_r    <= mul_lo_s;
                  result_hi_r <= mul_hi_s;
                  zero_r      <= (mul_lo_s == ALL_ZERO);
                  carry_r     <= (mul_hi_s != ALL_ZERO);
                  rem_r       <= 1'b0;
                  div_zero_r  <= 1'b0;
                  done_r      <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= MUL_ITER;
               end
            end
            DIV_ITER: begin
               hi_r  <= div_hi_s;
               lo_r  <= div_lo_s;
               cnt_r <= cnt_r - CNT_LAST;
               if (cnt_r == CNT_LAST) begin
                  result_r    <= div_lo_s;
                  result_hi_r <= div_hi_s;
                  zero_r      <= (div_lo_s == ALL_ZERO);
                  carry_r     <= 1'b0;
                  rem_r       <= (div_hi_s != ALL_ZERO);
                  div_zero_r  <= 1'b0;
                  done_r      <= 1'b1;
                  busy_r      <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= DIV_ITER;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy           = busy_r;
   assign bus.done           = done_r;
   assign bus.result_hi      = result_hi_r;
   assign bus.flag_zero      = zero_r;
   assign bus.flag_carry     = carry_r;
   assign bus.flag_remainder = rem_r;
   assign bus.flag_div_zero  = div_zero_r;

   // The enable gates only the bus driver; result_r keeps its value.
   assign result = bus.output_enable ? result_r : {WIDTH{1'bz}};

endmodule
